// File: rtl/jc_latch_arbiter_pkg.sv
// Shared definitions for the round-robin latch arbiter: FSM state encoding
// and the default sizing used by the top level and its picker.
package jc_latch_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_e;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_HOLD  = 2;

    // Next search start after a completed transfer by requester win.
    function automatic int next_ptr(input int win, input int nreq);
        return (win + 1 >= nreq) ? 0 : win + 1;
    endfunction

endpackage

// File: rtl/jc_latch_arbiter_rr_picker.sv
// Wrap-around first-set search: returns the first requester at or after ptr,
// so the FSM only ever sees an index and an "anyone asking" flag.
module rr_picker
    import jc_latch_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   pick,
    output logic            any
);

    int cand;

    // Walk from the farthest candidate back to ptr so the closest one wins last.
    always_comb begin
        pick = '0;
        cand = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (req[cand]) begin
                pick = cand[PW-1:0];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/jc_latch_arbiter.sv
// Round-robin controller for a shared capture register: grant, capture the
// winner's data, hold the grant for HOLD cycles, then release.
module jc_latch_arbiter
    import jc_latch_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int HOLD  = DEF_HOLD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      data_out,
    output logic                  data_valid,
    output logic                  busy
);

    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;

    arb_state_e        state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [HCW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;

    logic [PW-1:0]     pick;
    logic              any_req;

    rr_picker #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_picker (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
        end
    end

    // ack/data_valid default low so they only ever last one cycle.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        data_d     = data_q;
        valid_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    win_d       = pick;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    state_d     = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (req[win_q]) begin
                    data_d       = data_in[win_q*WIDTH +: WIDTH];
                    ack_d[win_q] = 1'b1;
                    valid_d      = 1'b1;
                    hold_cnt_d   = HCW'(HOLD - 1);
                    state_d      = ST_HOLD;
                end else begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            ST_HOLD: begin
                // Abort during hold still counts as a completed transfer.
                if (hold_cnt_q == '0 || !req[win_q]) begin
                    gnt_d   = '0;
                    ptr_d   = PW'(next_ptr(int'(win_q), NREQ));
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end

            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign gnt        = gnt_q;
    assign ack        = ack_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jc_latch_arbiter.sv
// Self-checking bench for jc_latch_arbiter: directed scenarios plus random
// transactions checked against a transaction-level round-robin model.
module tb_jc_latch_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int HOLD  = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data_in;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      data_out;
    logic                  data_valid;
    logic                  busy;

    int checks = 0;
    int errors = 0;
    int modelPtr;
    logic [WIDTH-1:0] modelData;

    jc_latch_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .HOLD  (HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data_in    (data_in),
        .gnt        (gnt),
        .ack        (ack),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requester found scanning ptr, ptr+1, ... mod NREQ.
    function automatic int model_pick(input int ptr, input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return 0;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic apply_reset;
        req = '0;
        data_in = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelPtr = 0;
        modelData = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        req = '1;
        data_in = NREQ*WIDTH'($urandom);
        #1;
        rst_n = 1'b0;
        #2;
        checks++; if (gnt !== '0) begin errors++; $display("[TB] FAIL reset_gnt: got %b want 0", gnt); end
        checks++; if (ack !== '0) begin errors++; $display("[TB] FAIL reset_ack: got %b want 0", ack); end
        checks++; if (data_out !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", data_out); end
        checks++; if (busy !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_valid: got %b%b want 00", busy, data_valid); end
        tick;
        checks++; if (gnt !== '0) begin errors++; $display("[TB] FAIL reset_held_gnt: got %b want 0", gnt); end
        rst_n = 1'b1;
        tick;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL reset_first_gnt: got %b want 0001", gnt); end
        req = '0;
    endtask

    task automatic test_single;
        apply_reset();
        req = 4'b0100;
        data_in = 16'h0600;
        tick;
        checks++; if (gnt !== 4'b0100 || busy !== 1'b1) begin errors++; $display("[TB] FAIL single_gnt: got %b busy %b want 0100 busy 1", gnt, busy); end
        checks++; if (ack !== '0) begin errors++; $display("[TB] FAIL single_early_ack: got %b want 0", ack); end
        tick;
        checks++; if (ack !== 4'b0100 || data_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_ack: got %b dv %b want 0100 dv 1", ack, data_valid); end
        checks++; if (data_out !== 4'h6) begin errors++; $display("[TB] FAIL single_data: got %h want 6", data_out); end
        tick;
        checks++; if (ack !== '0 || data_valid !== 1'b0 || gnt !== 4'b0100) begin errors++; $display("[TB] FAIL single_hold: got ack %b dv %b gnt %b want 0 0 0100", ack, data_valid, gnt); end
        tick;
        checks++; if (gnt !== '0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_release: got gnt %b busy %b want 0 0", gnt, busy); end
        req = '0;
        tick;
        checks++; if (gnt !== '0 || data_out !== 4'h6) begin errors++; $display("[TB] FAIL single_idle: got gnt %b data %h want 0 6", gnt, data_out); end
        modelPtr = 3;
        modelData = 4'h6;
    endtask

    task automatic test_rotation;
        logic [WIDTH-1:0] slices [NREQ];
        logic [NREQ-1:0]  expG;
        logic [NREQ-1:0]  expA;
        int phase;
        int idx;
        slices = '{4'h8, 4'h4, 4'h6, 4'h2};
        apply_reset();
        data_in = 16'h2648;
        req = 4'b1111;
        for (int n = 1; n <= 5 * (HOLD + 2); n++) begin
            tick;
            phase = (n - 1) % (HOLD + 2);
            idx = ((n - 1) / (HOLD + 2)) % NREQ;
            expG = (phase <= HOLD) ? onehot(idx) : '0;
            expA = (phase == 1) ? onehot(idx) : '0;
            checks++; if (gnt !== expG) begin errors++; $display("[TB] FAIL rotation_gnt cycle %0d: got %b want %b", n, gnt, expG); end
            checks++; if (ack !== expA) begin errors++; $display("[TB] FAIL rotation_ack cycle %0d: got %b want %b", n, ack, expA); end
            if (phase == 1) begin
                checks++; if (data_out !== slices[idx]) begin errors++; $display("[TB] FAIL rotation_data cycle %0d: got %h want %h", n, data_out, slices[idx]); end
            end
        end
        req = '0;
        tick;
        modelPtr = 1;
        modelData = 4'h8;
    endtask

    // mode 0: full transfer, 1: abort in LOAD, 2: early release one cycle after ack
    task automatic run_txn(input logic [NREQ-1:0] reqv, input int mode, input logic [NREQ*WIDTH-1:0] dvec);
        int win;
        logic [WIDTH-1:0] expD;
        win = model_pick(modelPtr, reqv);
        expD = dvec[win*WIDTH +: WIDTH];
        req = reqv;
        data_in = dvec;
        tick;
        checks++; if (gnt !== onehot(win) || busy !== 1'b1) begin errors++; $display("[TB] FAIL txn_gnt: got %b busy %b want %b busy 1", gnt, busy, onehot(win)); end
        if (mode == 1) begin
            req = reqv & ~onehot(win);
            tick;
            checks++; if (gnt !== '0 || ack !== '0 || data_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_outputs: got gnt %b ack %b dv %b want 0 0 0", gnt, ack, data_valid); end
            checks++; if (data_out !== modelData) begin errors++; $display("[TB] FAIL abort_data: got %h want %h", data_out, modelData); end
            req = '0;
            tick;
            checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
            return;
        end
        tick;
        checks++; if (ack !== onehot(win) || data_valid !== 1'b1) begin errors++; $display("[TB] FAIL txn_ack: got %b dv %b want %b dv 1", ack, data_valid, onehot(win)); end
        checks++; if (data_out !== expD) begin errors++; $display("[TB] FAIL txn_data: got %h want %h", data_out, expD); end
        modelData = expD;
        req = (NREQ'($urandom) & ~onehot(win)) | ((mode == 2) ? '0 : onehot(win));
        if (mode == 2) begin
            tick;
            checks++; if (gnt !== '0 || busy !== 1'b0 || ack !== '0) begin errors++; $display("[TB] FAIL early_release: got gnt %b busy %b ack %b want 0 0 0", gnt, busy, ack); end
        end else begin
            for (int c = 1; c <= HOLD; c++) begin
                tick;
                checks++; if (ack !== '0 || data_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_pulse: got ack %b dv %b want 0 0", ack, data_valid); end
                if (c < HOLD) begin
                    checks++; if (gnt !== onehot(win)) begin errors++; $display("[TB] FAIL hold_gnt: got %b want %b", gnt, onehot(win)); end
                    req = (NREQ'($urandom) & ~onehot(win)) | onehot(win);
                end else begin
                    checks++; if (gnt !== '0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL hold_release: got gnt %b busy %b want 0 0", gnt, busy); end
                end
            end
        end
        modelPtr = (win + 1) % NREQ;
        req = '0;
        tick;
        checks++; if (busy !== 1'b0 || data_out !== modelData) begin errors++; $display("[TB] FAIL post_idle: got busy %b data %h want 0 %h", busy, data_out, modelData); end
    endtask

    task automatic test_abort;
        apply_reset();
        run_txn(4'b0100, 0, 16'h0600);
        run_txn(4'b0010, 1, 16'h00A0);
        run_txn(4'b0011, 0, 16'h00B3);
    endtask

    task automatic test_early_release;
        apply_reset();
        run_txn(4'b1100, 0, 16'h1234);
        run_txn(4'b1000, 2, 16'h9000);
        run_txn(4'b1100, 0, 16'h5A00);
    endtask

    task automatic test_reset_mid_hold;
        apply_reset();
        req = 4'b0100;
        data_in = 16'h0500;
        tick;
        tick;
        checks++; if (gnt !== 4'b0100 || data_out !== 4'h5) begin errors++; $display("[TB] FAIL midhold_setup: got gnt %b data %h want 0100 5", gnt, data_out); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (gnt !== '0 || data_out !== '0) begin errors++; $display("[TB] FAIL midhold_async: got gnt %b data %h want 0 0", gnt, data_out); end
        checks++; if (busy !== 1'b0 || ack !== '0) begin errors++; $display("[TB] FAIL midhold_busy_ack: got busy %b ack %b want 0 0", busy, ack); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req = 4'b1111;
        tick;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL midhold_regrant: got %b want 0001", gnt); end
        req = '0;
    endtask

    task automatic test_random;
        logic [NREQ-1:0] reqv;
        apply_reset();
        for (int t = 0; t < 80; t++) begin
            reqv = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            run_txn(reqv, int'($urandom_range(0, 2)), NREQ*WIDTH'($urandom));
            if ($urandom_range(0, 3) == 0) tick;
        end
    endtask

    initial begin
        req = '0;
        data_in = '0;
        rst_n = 1'b1;
        test_reset();
        test_single();
        test_rotation();
        test_abort();
        test_early_release();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
